// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, request record and rotation helper for the
// register-file write arbiter and the read-port scheduler.
package cpu_pkg;

  // Write requester indices
  localparam logic [1:0] REQ_MOV    = 2'd0;
  localparam logic [1:0] REQ_ALU    = 2'd1;
  localparam logic [1:0] REQ_IMM    = 2'd2;
  localparam int         NUM_WR_REQ = 3;

  // Register file geometry
  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;

  // One requester's write request
  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;

  // (base + step) mod 3 for base, step in 0..2
  function automatic logic [1:0] rot3(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: request/ready bundle between the three write
// requesters (master side) and the write arbiter (slave side).
interface regfile_write_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);

  logic [NUM_WR_REQ-1:0]        req_valid;
  logic [NUM_WR_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_WR_REQ*DATA_W-1:0] req_data;
  logic [NUM_WR_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_pick3.sv
// rr_pick3: combinational 3-way rotating-priority picker. Searches ptr,
// ptr+1, ptr+2 (mod 3) and returns the first valid requester. A pointer
// value of 3 is treated as 0.
module rr_pick3
  import cpu_pkg::*;
(
  input  logic [1:0] ptr,
  input  logic [2:0] valid,
  output logic [2:0] grant,
  output logic [1:0] grant_idx
);

  logic [1:0] ptr_eff_s;
  logic [1:0] cand_s;
  logic       found_s;

  // Rotating first-valid search producing a one-hot grant and its index
  always_comb begin
    grant     = 3'b000;
    grant_idx = 2'd0;
    found_s   = 1'b0;
    cand_s    = 2'd0;
    if (ptr == 2'd3) begin
      ptr_eff_s = 2'd0;
    end else begin
      ptr_eff_s = ptr;
    end
    for (int k = 0; k < 3; k++) begin
      cand_s = rot3(ptr_eff_s, 2'(k));
      if (!found_s && valid[cand_s]) begin
        found_s   = 1'b1;
        grant_idx = cand_s;
        grant     = 3'b001 << cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between the
// MOV unit, ALU writeback and load-immediate with round-robin priority,
// registers the winning write, and raises a fetch stall on starvation.
module regfile_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enabled,
  input  logic                   flush,
  regfile_write_arbiter_if.slave req_if,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   stall,
  output logic [1:0]             last_grant
);

  logic [1:0]        ptr_r;
  logic [1:0]        last_grant_r;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic              stall_r;
  logic [WAIT_W-1:0] wait_cnt_r [NUM_WR_REQ];

  logic [2:0]        pick_grant_s;
  logic [1:0]        pick_idx_s;
  logic [2:0]        ready_s;
  logic [2:0]        accept_s;
  logic              accept_any_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [WAIT_W-1:0] wait_nxt_s [NUM_WR_REQ];
  logic              starve_s;

  rr_pick3 u_pick (
    .ptr       (ptr_r),
    .valid     (req_if.req_valid),
    .grant     (pick_grant_s),
    .grant_idx (pick_idx_s)
  );

  // Grants are suppressed while disabled, flushing or held in reset
  always_comb begin
    if (enabled && !flush && rst) begin
      ready_s = pick_grant_s;
    end else begin
      ready_s = 3'b000;
    end
    accept_s     = req_if.req_valid & ready_s;
    accept_any_s = |accept_s;
  end

  assign req_if.req_ready = ready_s;

  // Select the address/data of the picked requester
  always_comb begin
    case (pick_idx_s)
      REQ_MOV: begin
        sel_addr_s = req_if.req_addr[0 +: ADDR_W];
        sel_data_s = req_if.req_data[0 +: DATA_W];
      end
      REQ_ALU: begin
        sel_addr_s = req_if.req_addr[ADDR_W +: ADDR_W];
        sel_data_s = req_if.req_data[DATA_W +: DATA_W];
      end
      REQ_IMM: begin
        sel_addr_s = req_if.req_addr[2*ADDR_W +: ADDR_W];
        sel_data_s = req_if.req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        sel_addr_s = req_if.req_addr[0 +: ADDR_W];
        sel_data_s = req_if.req_data[0 +: DATA_W];
      end
    endcase
  end

  // Next wait counts (saturating) and the starvation condition they imply
  always_comb begin
    starve_s = 1'b0;
    for (int i = 0; i < NUM_WR_REQ; i++) begin
      wait_nxt_s[i] = wait_cnt_r[i];
    end
    for (int i = 0; i < NUM_WR_REQ; i++) begin
      if (flush || !req_if.req_valid[i] || accept_s[i]) begin
        wait_nxt_s[i] = {WAIT_W{1'b0}};
      end else if (wait_cnt_r[i] == {WAIT_W{1'b1}}) begin
        wait_nxt_s[i] = wait_cnt_r[i];
      end else begin
        wait_nxt_s[i] = wait_cnt_r[i] + {{(WAIT_W-1){1'b0}}, 1'b1};
      end
      if (wait_nxt_s[i] >= WAIT_W'(MAX_WAIT)) begin
        starve_s = 1'b1;
      end else begin
        starve_s = starve_s;
      end
    end
  end

  // Rotation pointer moves past the winner; flush returns it to MOV
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r        <= 2'd0;
      last_grant_r <= 2'd0;
    end else if (flush) begin
      ptr_r        <= 2'd0;
    end else if (accept_any_s) begin
      ptr_r        <= rot3(pick_idx_s, 2'd1);
      last_grant_r <= pick_idx_s;
    end
  end

  // Registered write port; address/data hold when nothing is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
    end else begin
      rf_we_r <= accept_any_s;
      if (accept_any_s) begin
        rf_waddr_r <= sel_addr_s;
        rf_wdata_r <= sel_data_s;
      end
    end
  end

  // Per-requester wait counters and the registered fetch stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WR_REQ; i++) begin
        wait_cnt_r[i] <= {WAIT_W{1'b0}};
      end
      stall_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WR_REQ; i++) begin
        wait_cnt_r[i] <= wait_nxt_s[i];
      end
      stall_r <= starve_s;
    end
  end

  assign rf_we      = rf_we_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = rf_wdata_r;
  assign stall      = stall_r;
  assign last_grant = last_grant_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_regfile_write_arbiter;
  import cpu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int WW = 4;
  localparam int MW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enabled = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      v = 3'b000;
  logic [3*AW-1:0] a_flat = '0;
  logic [3*DW-1:0] d_flat = '0;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic            stall;
  logic [1:0]      last_grant;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  assign bus.req_valid = v;
  assign bus.req_addr  = a_flat;
  assign bus.req_data  = d_flat;

  regfile_write_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .WAIT_W(WW), .MAX_WAIT(MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enabled    (enabled),
    .flush      (flush),
    .req_if     (bus),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall      (stall),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_ptr, m_last, last_g;
  int m_cnt [3];
  int m_addr, m_data;
  bit m_we, m_stall;

  function automatic void model_reset();
    m_ptr = 0; m_last = 0; m_addr = 0; m_data = 0;
    m_we = 1'b0; m_stall = 1'b0; last_g = -1;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endfunction

  // Requester the rules would grant this cycle, -1 when none
  function automatic int pick(input logic [2:0] vv);
    if (!enabled || flush || !rst) return -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (vv[i]) return i;
    end
    return -1;
  endfunction

  // Advance one clock and update the model from this cycle's inputs
  task automatic tick();
    int g;
    g = pick(v);
    @(posedge clk);
    if (g >= 0) begin
      m_we = 1'b1; m_addr = int'(a_flat[g*AW +: AW]); m_data = int'(d_flat[g*DW +: DW]);
      m_last = g; m_ptr = (g + 1) % 3;
    end else begin
      m_we = 1'b0;
    end
    if (flush) m_ptr = 0;
    m_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (flush || !v[i] || g == i) m_cnt[i] = 0;
      else if (m_cnt[i] < (1 << WW) - 1) m_cnt[i] = m_cnt[i] + 1;
      if (m_cnt[i] >= MW) m_stall = 1'b1;
    end
    last_g = g;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; v = 3'b000; enabled = 1'b0; flush = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    enabled = 1'b1; v = 3'b111;
    #2 rst = 1'b0;
    #5;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
    checks++; if (rf_waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
    checks++; if (rf_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %0h want 0", rf_wdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
    checks++; if (last_grant !== 2'd0) begin errors++; $display("FAIL reset_last_grant: got %0d want 0", last_grant); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", bus.req_ready); end
    model_reset();
    @(negedge clk);
    rst = 1'b1; v = 3'b000;
  endtask

  task automatic test_idle();
    enabled = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL idle_ready: cycle %0d got %b want 000", c, bus.req_ready); end
      tick();
      checks++; if (rf_we !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL idle_out: cycle %0d got we=%0b stall=%0b want 0/0", c, rf_we, stall); end
    end
  endtask

  task automatic test_single();
    enabled = 1'b1; v = 3'b010;
    a_flat[AW +: AW] = 3'd5; d_flat[DW +: DW] = 8'h3C;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b want 010", bus.req_ready); end
    tick();
    v = 3'b000;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== 8'h3C) begin errors++; $display("FAIL single_write: got we=%0b a=%0d d=%0h want 1/5/3c", rf_we, rf_waddr, rf_wdata); end
    checks++; if (last_grant !== 2'd1) begin errors++; $display("FAIL single_last_grant: got %0d want 1", last_grant); end
    tick();
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 3'd5 || rf_wdata !== 8'h3C) begin errors++; $display("FAIL single_hold: got we=%0b a=%0d d=%0h want 0/5/3c", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_rotation();
    reset_dut();
    enabled = 1'b1; v = 3'b111;
    a_flat = {3'd3, 3'd2, 3'd1};
    d_flat = {8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 6; k++) begin
      int e;
      logic [2:0] er;
      logic [7:0] ed;
      e = k % 3;
      er = 3'b001 << e;
      ed = 8'h11 * 8'(e + 1);
      #1;
      checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL rot_ready: step %0d got %b want %b", k, bus.req_ready, er); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_wdata !== ed || rf_waddr !== 3'(e + 1)) begin errors++; $display("FAIL rot_write: step %0d got we=%0b a=%0d d=%0h want 1/%0d/%0h", k, rf_we, rf_waddr, rf_wdata, e + 1, ed); end
      checks++; if (last_grant !== 2'(e)) begin errors++; $display("FAIL rot_last_grant: step %0d got %0d want %0d", k, last_grant, e); end
    end
    v = 3'b000;
  endtask

  task automatic test_stall();
    reset_dut();
    enabled = 1'b0; v = 3'b001;
    a_flat[0 +: AW] = 3'd4; d_flat[0 +: DW] = 8'h99;
    for (int c = 1; c <= 20; c++) begin
      logic es;
      es = (c >= 3);
      #1;
      checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready_dis: cycle %0d got %b want 000", c, bus.req_ready); end
      tick();
      checks++; if (stall !== es) begin errors++; $display("FAIL stall_level: cycle %0d got %0b want %0b", c, stall, es); end
    end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL stall_no_write: got %0b want 0", rf_we); end
    enabled = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL stall_grant: got %b want 001", bus.req_ready); end
    tick();
    v = 3'b000;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 8'h99 || stall !== 1'b0) begin errors++; $display("FAIL stall_release: got we=%0b d=%0h stall=%0b want 1/99/0", rf_we, rf_wdata, stall); end
  endtask

  task automatic test_flush();
    reset_dut();
    enabled = 1'b0; v = 3'b110;
    a_flat[AW +: AW] = 3'd2; d_flat[DW +: DW] = 8'hA1;
    a_flat[2*AW +: AW] = 3'd6; d_flat[2*DW +: DW] = 8'hB2;
    tick(); tick(); tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %0b want 1", stall); end
    enabled = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL flush_pre_grant: got %b want 010", bus.req_ready); end
    tick();
    d_flat[DW +: DW] = 8'hC3;
    flush = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL flush_ready: got %b want 000", bus.req_ready); end
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 8'hA1 || stall !== 1'b1) begin errors++; $display("FAIL flush_pending: got we=%0b d=%0h stall=%0b want 1/a1/1", rf_we, rf_wdata, stall); end
    tick();
    flush = 1'b0;
    checks++; if (rf_we !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_after: got we=%0b stall=%0b want 0/0", rf_we, stall); end
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL flush_ptr0: got %b want 010", bus.req_ready); end
    tick();
    v = 3'b000;
    checks++; if (rf_wdata !== 8'hC3 || last_grant !== 2'd1) begin errors++; $display("FAIL flush_alu_first: got d=%0h lg=%0d want c3/1", rf_wdata, last_grant); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    enabled = 1'b1; v = 3'b001;
    a_flat[0 +: AW] = 3'd7; d_flat[0 +: DW] = 8'h5A;
    tick();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL arst_pre: got %0b want 1", rf_we); end
    #2 rst = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_wdata !== 8'h00 || last_grant !== 2'd0) begin errors++; $display("FAIL arst_immediate: got we=%0b d=%0h lg=%0d want 0/0/0", rf_we, rf_wdata, last_grant); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL arst_ready: got %b want 000", bus.req_ready); end
    model_reset();
    @(negedge clk);
    rst = 1'b1; v = 3'b000;
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL arst_replay: got %0b want 0", rf_we); end
    v = 3'b111;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL arst_ptr0: got %b want 001", bus.req_ready); end
    tick();
    v = 3'b000;
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [2:0] er;
      for (int i = 0; i < 3; i++) begin
        if (v[i] && last_g != i) begin
          if ($urandom_range(0, 9) == 0) v[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 6) begin
          v[i] = 1'b1;
          a_flat[i*AW +: AW] = AW'($urandom);
          d_flat[i*DW +: DW] = DW'($urandom);
        end else begin
          v[i] = 1'b0;
        end
      end
      enabled = (c % 50 >= 40) ? 1'b0 : ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 19) == 0);
      g = pick(v);
      er = (g < 0) ? 3'b000 : (3'b001 << g);
      #1;
      checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL rand_ready: cycle %0d got %b want %b", c, bus.req_ready, er); end
      tick();
      checks++; if (rf_we !== m_we || stall !== m_stall || last_grant !== 2'(m_last)) begin errors++; $display("FAIL rand_ctrl: cycle %0d got we=%0b st=%0b lg=%0d want %0b/%0b/%0d", c, rf_we, stall, last_grant, m_we, m_stall, m_last); end
      checks++; if (rf_waddr !== AW'(m_addr) || rf_wdata !== DW'(m_data)) begin errors++; $display("FAIL rand_data: cycle %0d got a=%0d d=%0h want %0d/%0h", c, rf_waddr, rf_wdata, m_addr, m_data); end
    end
    v = 3'b000; flush = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_single();
    test_rotation();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between three requesters: 0 = MOV unit, 1 = ALU writeback, 2 = load-immediate.
- Grants at most one requester per cycle, using rotating (round-robin) priority, and drives a registered write onto the register file.
- Tracks how long each requester has waited and raises a fetch stall when any requester is starved.
- Sits between the execute units and the 8-entry register file; the decode stage drives `enabled`.

Parameters:
- DATA_W, 8, register data width.
- ADDR_W, 3, register address width (8 registers).
- WAIT_W, 4, width of each per-requester wait counter.
- MAX_WAIT, 3, wait count at or above which `stall` is asserted.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enabled  input  1  arbitration enable from decode.
- flush  input  1  synchronous clear of the rotation pointer and wait counters.
- req_valid  input  3  per-requester write request.
- req_addr  input  3*ADDR_W  per-requester destination; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  3*DATA_W  per-requester write data; same packing as `req_addr`.
- req_ready  output  3  combinational grant; a transfer happens when valid & ready.
- rf_we  output  1  registered register-file write enable.
- rf_waddr  output  ADDR_W  registered write address.
- rf_wdata  output  DATA_W  registered write data.
- stall  output  1  registered starvation stall to fetch.
- last_grant  output  2  registered index of the most recent granted requester (debug).

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0, stall=0, last_grant=0.
  - Rotation pointer = 0; all wait counters = 0.
- Requester handshake:
  - A requester holds valid, addr and data stable until it sees valid & ready.
  - Deasserting valid before acceptance is legal; the request is dropped and its counter clears.
- req_ready is combinational:
  - All zero when enabled=0, flush=1 or rst=0.
  - Otherwise exactly one bit is set: the first valid requester searching ptr, ptr+1, ptr+2 (mod 3).
  - All zero when no requester is valid.
- Write path, 1-cycle latency: an accept in cycle N gives rf_we=1 in N+1, with that requester's addr/data. With no accept in N, rf_we=0 in N+1 and rf_waddr/rf_wdata hold their previous values.
- Pointer update on accept of requester g: ptr <= (g+1) mod 3, last_grant <= g. With no accept, ptr holds.
- Wait counter i, updated each cycle:
  - Cleared if flush, or !req_valid[i], or requester i is accepted.
  - Otherwise incremented, saturating at 2^WAIT_W-1.
  - Counters keep counting while enabled=0; a disabled arbiter starves its requesters.
- stall: registered; set next cycle when any counter, after its update, is >= MAX_WAIT. It deasserts the cycle after all counters fall below MAX_WAIT.
- flush:
  - Sets ptr <= 0 and clears all counters; stall goes low next cycle.
  - No grants are given in a flush cycle.
  - A write already registered (rf_we=1 this cycle) still completes; it is not cancelled.
- Simultaneous events:
  - Two or three valid requesters: only the requester chosen by rotation is granted.
  - Back-to-back writes to the same address are both issued, in grant order; the last one wins.
  - flush together with enabled=1: flush dominates.
- No state machine beyond the pointer register (values 0..2); the pointer never holds 3. If it is forced to 3, it is treated as 0.

Decomposition:
- Shared package `cpu_pkg`:
  - REQ_MOV=0, REQ_ALU=1, REQ_IMM=2, NUM_WR_REQ=3.
  - DATA_W and ADDR_W constants.
  - typedef `wr_req_t {valid, addr, data}`.
- One natural sub-module, `rr_pick3`: a combinational 3-way rotating-priority picker. Inputs are ptr and valid; outputs are a one-hot grant and the grant index. It is reused later by the read-port scheduler.
- Wait counters and output registers stay in the top module.

Test Plan:
- Reset then idle: release rst with no valid -> rf_we=0, stall=0, req_ready=000 for 10 cycles.
- Single requester: ALU valid, addr=5, data=0x3C, enabled=1 -> req_ready=010 in cycle N; rf_we=1, rf_waddr=5, rf_wdata=0x3C in N+1; last_grant=1.
- Rotation: all three valid continuously from reset -> grant order 0,1,2,0,1,2. Each requester sees its data on rf_wdata exactly one cycle after its ready.
- Starvation stall: enabled=0 with MOV valid for 4 cycles -> counter reaches 3 on cycle 3 and stall=1 from cycle 4. Then set enabled=1 -> MOV granted and stall=0 the cycle after.
- Flush mid-operation: rf_we=1 pending, flush=1 with ALU and IMM valid -> write still appears, req_ready=000 that cycle, ptr=0. Next cycle (no flush) ALU is granted first.
- Async reset mid-write: rst low mid-cycle while rf_we=1 -> rf_we=0 immediately, without waiting for a clock edge; after release, ptr=0 and no write is replayed.
